// File: rtl/multicycle_control_if.sv
// multicycle_control_if: IR/flag inputs and datapath control strobes.
// The mem_ready handshake exists only when CTRL_MEM_WAIT_EN is defined.
interface multicycle_control_if;
    logic [10:0] inst31_21;
    logic        zero;
`ifdef CTRL_MEM_WAIT_EN
    logic        mem_ready;
`endif
    logic [1:0]  ALUOp;
    logic        ALUSrc;
    logic        Reg2Loc;
    logic        MemRead;
    logic        MemWrite;
    logic        MemtoReg;
    logic        RegWrite;
    logic        ir_write;
    logic        pc_write;
    logic        pc_src;
    logic        illegal;
    logic [2:0]  state;

`ifdef CTRL_MEM_WAIT_EN
    modport master (
        input  inst31_21, zero, mem_ready,
        output ALUOp, ALUSrc, Reg2Loc, MemRead, MemWrite, MemtoReg,
        output RegWrite, ir_write, pc_write, pc_src, illegal, state
    );
    modport slave (
        output inst31_21, zero, mem_ready,
        input  ALUOp, ALUSrc, Reg2Loc, MemRead, MemWrite, MemtoReg,
        input  RegWrite, ir_write, pc_write, pc_src, illegal, state
    );
`else
    modport master (
        input  inst31_21, zero,
        output ALUOp, ALUSrc, Reg2Loc, MemRead, MemWrite, MemtoReg,
        output RegWrite, ir_write, pc_write, pc_src, illegal, state
    );
    modport slave (
        output inst31_21, zero,
        input  ALUOp, ALUSrc, Reg2Loc, MemRead, MemWrite, MemtoReg,
        input  RegWrite, ir_write, pc_write, pc_src, illegal, state
    );
`endif
endinterface

// File: rtl/multicycle_control.sv
// multicycle_control: LEGv8 multicycle main control FSM.
// Define CTRL_MEM_WAIT_EN for the mem_ready wait with MEM_TIMEOUT abort.
module multicycle_control
`ifdef CTRL_MEM_WAIT_EN
  #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 4
  )
`endif
  (
    input  logic                clk,
    input  logic                reset,
    multicycle_control_if.master bus
  );

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        C_NONE, C_R, C_ADDI, C_LDUR, C_STUR, C_CBZ, C_B, C_ILL
    } cls_t;

    state_t      st, st_nx;
    cls_t        cls_d, cls_q, cls;
    logic [10:0] op;
    logic        ready, tmo;

    logic [1:0] alu_op;
    logic       alu_src, reg2loc, mem_rd, mem_wr, mem2reg;
    logic       reg_wr, ir_wr, pc_wr, pc_sel, ill;

    assign op = bus.inst31_21;

    always_comb begin
        cls_d = C_ILL;
        unique case (1'b1)
            op == 11'b10001011000,
            op == 11'b11001011000,
            op == 11'b10001010000,
            op == 11'b10101010000:      cls_d = C_R;
            op[10:1] == 10'b1001000100: cls_d = C_ADDI;
            op == 11'b11111000010:      cls_d = C_LDUR;
            op == 11'b11111000000:      cls_d = C_STUR;
            op[10:3] == 8'b10110100:    cls_d = C_CBZ;
            op[10:5] == 6'b000101:      cls_d = C_B;
            default:                    cls_d = C_ILL;
        endcase
    end

    // Live decode in DECODE gives alu_control a cycle to register ALUOp.
    assign cls = (st == DECODE) ? cls_d : cls_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st    <= FETCH;
            cls_q <= C_NONE;
        end else begin
            st <= st_nx;
            if (st == DECODE)
                cls_q <= cls_d;
        end
    end

`ifdef CTRL_MEM_WAIT_EN
    logic [CNT_W-1:0] cnt;

    assign ready = bus.mem_ready;
    assign tmo   = (cnt == CNT_W'(MEM_TIMEOUT));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (st == MEM && !ready && !tmo)
            cnt <= cnt + 1'b1;
        else
            cnt <= '0;
    end
`else
    assign ready = 1'b1;
    assign tmo   = 1'b0;
`endif

    always_comb begin
        st_nx   = st;
        alu_op  = 2'b00;
        alu_src = 1'b0;
        reg2loc = 1'b0;
        mem_rd  = 1'b0;
        mem_wr  = 1'b0;
        mem2reg = 1'b0;
        reg_wr  = 1'b0;
        ir_wr   = 1'b0;
        pc_wr   = 1'b0;
        pc_sel  = 1'b0;
        ill     = 1'b0;

        case (st)
            FETCH: begin
                ir_wr = 1'b1;
                pc_wr = 1'b1;
                st_nx = DECODE;
            end
            DECODE: begin
                ill   = (cls_d == C_ILL);
                st_nx = (cls_d == C_ILL) ? FETCH : EXEC;
            end
            EXEC: begin
                case (cls)
                    C_R, C_ADDI:    st_nx = WB;
                    C_LDUR, C_STUR: st_nx = MEM;
                    C_CBZ: begin
                        pc_wr  = bus.zero;
                        pc_sel = 1'b1;
                        st_nx  = FETCH;
                    end
                    C_B: begin
                        pc_wr  = 1'b1;
                        pc_sel = 1'b1;
                        st_nx  = FETCH;
                    end
                    default:        st_nx = FETCH;
                endcase
            end
            MEM: begin
                if (tmo) begin
                    ill   = 1'b1;
                    st_nx = FETCH;
                end else begin
                    mem_rd = (cls == C_LDUR);
                    mem_wr = (cls == C_STUR);
                    if (ready)
                        st_nx = (cls == C_LDUR) ? WB : FETCH;
                end
            end
            WB: begin
                reg_wr  = 1'b1;
                mem2reg = (cls == C_LDUR);
                st_nx   = FETCH;
            end
            default: st_nx = FETCH;
        endcase

        if (st != FETCH) begin
            case (cls)
                C_R:    alu_op = 2'b10;
                C_ADDI: begin alu_op = 2'b10; alu_src = 1'b1; end
                C_LDUR: alu_src = 1'b1;
                C_STUR: begin alu_src = 1'b1; reg2loc = 1'b1; end
                C_CBZ:  begin alu_op = 2'b01; reg2loc = 1'b1; end
                default: ;
            endcase
        end

        // Async reset silences every strobe in the same cycle.
        if (reset) begin
            alu_op  = 2'b00;
            alu_src = 1'b0;
            reg2loc = 1'b0;
            mem_rd  = 1'b0;
            mem_wr  = 1'b0;
            mem2reg = 1'b0;
            reg_wr  = 1'b0;
            ir_wr   = 1'b0;
            pc_wr   = 1'b0;
            pc_sel  = 1'b0;
            ill     = 1'b0;
        end
    end

    assign bus.ALUOp    = alu_op;
    assign bus.ALUSrc   = alu_src;
    assign bus.Reg2Loc  = reg2loc;
    assign bus.MemRead  = mem_rd;
    assign bus.MemWrite = mem_wr;
    assign bus.MemtoReg = mem2reg;
    assign bus.RegWrite = reg_wr;
    assign bus.ir_write = ir_wr;
    assign bus.pc_write = pc_wr;
    assign bus.pc_src   = pc_sel;
    assign bus.illegal  = ill;
    assign bus.state    = st;

endmodule
